// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle RV32 subset control sequencer
// Shared memory port for fetch and data; sticky illegal/timeout traps.
module multicycle_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [6:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_pc_src,
  output logic             o_ir_write,
  output logic             o_iord,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_alu_src,
  output logic [1:0]       o_alu_op,
  output logic             o_reg_write,
  output logic             o_mem_to_reg,
  output logic [2:0]       o_state,
  output logic             o_illegal,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_instr_count
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R  = 3'd0,
    C_I  = 3'd1,
    C_LD = 3'd2,
    C_ST = 3'd3,
    C_BR = 3'd4
  } class_t;

  state_t              r_state;
  state_t              w_next;
  class_t              r_class;
  class_t              w_class;
  logic                w_legal;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_illegal;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_count;
  logic                w_retire;
  logic                w_set_illegal;
  logic                w_set_timeout;
  logic                w_expired;

  always_comb begin
    w_class = C_R;
    w_legal = 1'b1;
    case (i_opcode)
      7'b0110011: w_class = C_R;
      7'b0010011: w_class = C_I;
      7'b0000011: w_class = C_LD;
      7'b0100011: w_class = C_ST;
      7'b1100011: w_class = C_BR;
      default:    w_legal = 1'b0;
    endcase
  end

  assign w_expired = (r_wait == WAIT_LAST);

  always_comb begin
    o_pc_write    = 1'b0;
    o_pc_src      = 1'b0;
    o_ir_write    = 1'b0;
    o_iord        = 1'b0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_alu_src     = 1'b0;
    o_alu_op      = 2'b00;
    o_reg_write   = 1'b0;
    o_mem_to_reg  = 1'b0;
    w_next        = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_read = 1'b1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_expired) begin
          w_next        = S_TRAP;
          w_set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next        = S_TRAP;
          w_set_illegal = 1'b1;
        end
      end
      S_EXEC: begin
        case (r_class)
          C_R: begin
            o_alu_op = 2'b10;
            w_next   = S_WB;
          end
          C_I: begin
            o_alu_src = 1'b1;
            o_alu_op  = 2'b10;
            w_next    = S_WB;
          end
          C_LD, C_ST: begin
            o_alu_src = 1'b1;
            w_next    = S_MEM;
          end
          C_BR: begin
            o_alu_op   = 2'b01;
            o_pc_src   = 1'b1;
            o_pc_write = i_zero;
            w_next     = S_FETCH;
            w_retire   = 1'b1;
          end
          default: w_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        o_iord      = 1'b1;
        o_mem_read  = (r_class == C_LD);
        o_mem_write = (r_class == C_ST);
        if (i_mem_ready) begin
          if (r_class == C_LD) begin
            w_next = S_WB;
          end else begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end else if (w_expired) begin
          w_next        = S_TRAP;
          w_set_timeout = 1'b1;
        end
      end
      S_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = (r_class == C_LD);
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
    // FETCH is the reset state but must not request memory while reset is held.
    if (!i_rst_n) begin
      o_pc_write  = 1'b0;
      o_ir_write  = 1'b0;
      o_mem_read  = 1'b0;
      o_mem_write = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_FETCH;
      r_class   <= C_R;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_class <= w_class;
      end
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if ((r_state == S_FETCH || r_state == S_MEM) && !i_mem_ready) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
      if (w_retire) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_state       = r_state;
  assign o_illegal     = r_illegal;
  assign o_timeout     = r_timeout;
  assign o_instr_count = r_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed plus randomized bench for multicycle_sequencer
// Expected strobes come from a per-instruction phase walk of the instruction rules.
module tb_multicycle_sequencer;

  localparam int TO = 16;
  localparam int CW = 4;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [10:0] B_PCW = 11'b100_0000_0000;
  localparam logic [10:0] B_PCS = 11'b010_0000_0000;
  localparam logic [10:0] B_IRW = 11'b001_0000_0000;
  localparam logic [10:0] B_IOD = 11'b000_1000_0000;
  localparam logic [10:0] B_MR  = 11'b000_0100_0000;
  localparam logic [10:0] B_MW  = 11'b000_0010_0000;
  localparam logic [10:0] B_AS  = 11'b000_0001_0000;
  localparam logic [10:0] B_OP1 = 11'b000_0000_0100;
  localparam logic [10:0] B_OP2 = 11'b000_0000_1000;
  localparam logic [10:0] B_RW  = 11'b000_0000_0010;
  localparam logic [10:0] B_M2R = 11'b000_0000_0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic          zero = 1'b0;
  logic          ready = 1'b0;
  logic          pc_write, pc_src, ir_write, iord, mem_read, mem_write;
  logic          alu_src, reg_write, mem_to_reg, illegal, timeout;
  logic [1:0]    alu_op;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;
  logic [10:0]   strb;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int m_cnt = 0;
  bit m_ill = 1'b0;
  bit m_to = 1'b0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_zero(zero),
    .i_mem_ready(ready), .o_pc_write(pc_write), .o_pc_src(pc_src),
    .o_ir_write(ir_write), .o_iord(iord), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_alu_src(alu_src), .o_alu_op(alu_op),
    .o_reg_write(reg_write), .o_mem_to_reg(mem_to_reg), .o_state(state),
    .o_illegal(illegal), .o_timeout(timeout), .o_instr_count(instr_count)
  );

  assign strb = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                 alu_src, alu_op, reg_write, mem_to_reg};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR};
  endfunction

  task automatic step(input string tag, input logic [2:0] est, input logic [10:0] estr);
    #1;
    chk({tag, "_state"}, 32'(state), 32'(est));
    chk({tag, "_strb"}, 32'(strb), 32'(estr));
    @(negedge clk);
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, "_count"}, 32'(instr_count), 32'(m_cnt));
    chk({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
    chk({tag, "_timeout"}, 32'(timeout), 32'(m_to));
  endtask

  task automatic retire();
    m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  task automatic run_instr(input logic [6:0] op, input int fd, input int md,
                           input bit z, output bit trapped);
    bit is_ld, is_st;
    trapped = 1'b0;
    is_ld = (op == OP_LD);
    is_st = (op == OP_ST);
    for (int i = 0; i < TO; i++) begin
      ready = (i == fd);
      zero = 1'($urandom);
      opcode = 7'($urandom);
      if (ready) begin
        step("fetch", 3'd0, B_MR | B_IRW | B_PCW);
        break;
      end
      step("fetch", 3'd0, B_MR);
      if (i == TO - 1) begin
        m_to = 1'b1;
        trapped = 1'b1;
        return;
      end
    end
    ready = 1'($urandom);
    opcode = op;
    step("decode", 3'd1, 11'd0);
    if (!legal(op)) begin
      m_ill = 1'b1;
      trapped = 1'b1;
      return;
    end
    opcode = 7'($urandom);
    ready = 1'($urandom);
    zero = z;
    if (op == OP_BR) begin
      step("exec_br", 3'd2, ({11{z}} & B_PCW) | B_PCS | B_OP1);
      retire();
      return;
    end
    if (op == OP_R)        step("exec_r", 3'd2, B_OP2);
    else if (op == OP_I)   step("exec_i", 3'd2, B_AS | B_OP2);
    else                   step("exec_ls", 3'd2, B_AS);
    if (is_ld || is_st) begin
      for (int i = 0; i < TO; i++) begin
        ready = (i == md);
        opcode = 7'($urandom);
        step("mem", 3'd3, B_IOD | ({11{is_ld}} & B_MR) | ({11{is_st}} & B_MW));
        if (ready) break;
        if (i == TO - 1) begin
          m_to = 1'b1;
          trapped = 1'b1;
          return;
        end
      end
      if (is_st) begin
        retire();
        return;
      end
    end
    ready = 1'($urandom);
    opcode = 7'($urandom);
    step("wb", 3'd4, B_RW | ({11{is_ld}} & B_M2R));
    retire();
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) begin
      ready = 1'($urandom);
      zero = 1'($urandom);
      opcode = 7'($urandom);
      step("trap", 3'd7, 11'd0);
    end
    chk_arch("trap");
  endtask

  task automatic do_reset();
    ready = 1'b1;
    #2;
    rst_n = 1'b0;
    m_cnt = 0;
    m_ill = 1'b0;
    m_to = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strb", 32'(strb), 32'd0);
    chk_arch("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit tr;
    logic [6:0] op;
    int fd, md;
    logic [6:0] ops [5];
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST; ops[4] = OP_BR;

    ready = 1'b1;
    #2;
    chk("por_state", 32'(state), 32'd0);
    chk("por_strb", 32'(strb), 32'd0);
    chk_arch("por");
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(OP_R, 0, 0, 1'b0, tr);
    chk("r_trap", 32'(tr), 32'd0);
    chk_arch("r");
    run_instr(OP_LD, 3, 3, 1'b0, tr);
    chk_arch("ld");
    run_instr(OP_BR, 0, 0, 1'b1, tr);
    run_instr(OP_BR, 1, 0, 1'b0, tr);
    chk_arch("br");

    run_instr(7'b1111111, 0, 0, 1'b0, tr);
    chk("ill_trap", 32'(tr), 32'd1);
    trap_hold(20);
    do_reset();

    run_instr(OP_ST, 0, 99, 1'b0, tr);
    chk("st_to_trap", 32'(tr), 32'd1);
    trap_hold(3);
    do_reset();
    run_instr(OP_ST, 15, 15, 1'b0, tr);
    chk("st_late_trap", 32'(tr), 32'd0);
    chk_arch("st_late");
    run_instr(OP_LD, 16, 0, 1'b0, tr);
    chk("fetch_to_trap", 32'(tr), 32'd1);
    trap_hold(2);
    do_reset();

    for (int k = 0; k < 17; k++) begin
      run_instr(OP_I, $urandom_range(0, 2), 0, 1'b0, tr);
    end
    chk_arch("wrap");
    ready = 1'b1;
    step("f18", 3'd0, B_MR | B_IRW | B_PCW);
    opcode = OP_I;
    step("d18", 3'd1, 11'd0);
    #1;
    chk("e18_state", 32'(state), 32'd2);
    do_reset();

    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 15) == 0) begin
        do op = 7'($urandom); while (legal(op));
      end
      fd = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, 3);
      md = ($urandom_range(0, 19) == 0) ? TO + 2 : $urandom_range(0, 3);
      run_instr(op, fd, md, 1'($urandom), tr);
      chk_arch("rnd");
      if (tr) begin
        trap_hold(2);
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM that sequences the RV32 subset datapath: fetch, decode, execute, memory and write-back over several clocks. A single shared memory port serves both instruction fetch and data access, and the block handles it with a ready handshake. Control strobes are driven to the PC, instruction register, register file, ALU control, muxes and memory. The block sits between the instruction register opcode field and every datapath enable.

Parameters:
CNT_W, 32, width of retired-instruction counter
TIMEOUT, 16, max cycles waiting for mem_ready before trapping (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  7  Instruction[6:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  load PC this cycle
pc_src  out  1  0=PC+4, 1=branch target
ir_write  out  1  load instruction register
iord  out  1  memory address select: 0=PC, 1=ALUResult
mem_read  out  1  memory read request
mem_write  out  1  memory write request
alu_src  out  1  0=register rs2, 1=immediate
alu_op  out  2  00 add (ld/st), 01 sub (branch), 10 funct-decoded (R/I)
reg_write  out  1  register file write enable
mem_to_reg  out  1  write-back source: 1=ReadData, 0=ALUResult
state  out  3  current state encoding
illegal  out  1  sticky: undecodable opcode seen
timeout  out  1  sticky: memory handshake timed out
instr_count  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Codes 5 and 6 are unreachable and go to TRAP.
- Reset (reset=0, async): state=FETCH, illegal=0, timeout=0, instr_count=0, wait counter=0. All strobes deassert immediately, not waiting for a clock edge.
- Strobes are combinational from state. Exceptions: ir_write, pc_write and the exits from FETCH/MEM are also qualified by mem_ready or zero, as listed below.
- Every strobe not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0.
  - While mem_ready=0: hold.
  - Cycle with mem_ready=1: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
- DECODE: one cycle, no strobes. Next state depends on opcode:
  - 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch): EXEC.
  - Any other value: TRAP, and illegal is set.
- EXEC, by instruction type:
  - R: alu_src=0, alu_op=10; next WB.
  - I-ALU: alu_src=1, alu_op=10; next WB.
  - Load/store: alu_src=1, alu_op=00; next MEM.
  - Branch: alu_src=0, alu_op=01, pc_src=1, pc_write=zero; next FETCH; the instruction retires.
  - The opcode latched in DECODE is used, so opcode changes after DECODE are ignored.
- MEM:
  - iord=1; mem_read=1 for load, mem_write=1 for store. Both are held constant until mem_ready=1.
  - On ready, load goes to WB. Store goes to FETCH and retires.
- WB:
  - reg_write=1 for one cycle; mem_to_reg=1 for load, 0 otherwise.
  - Next state FETCH; the instruction retires.
- Retire: instr_count increments by 1 on the clock edge that leaves a retiring state. Wraps all-ones to 0.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM.
  - It increments on each cycle in FETCH or MEM with mem_ready=0.
  - If it reaches TIMEOUT-1 and mem_ready is still 0, the next state is TRAP and timeout is set.
  - mem_ready=1 on that same cycle wins: normal transition, no timeout.
- TRAP: all strobes 0; stays in TRAP until reset. instr_count is frozen.
- Reset asserted mid-instruction aborts the instruction: no retire, no strobe glitch past the reset edge.
- mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset, then an R-type (0110011) with mem_ready=1 on first FETCH cycle -> state sequence 0,1,2,4,0. reg_write high only in WB. instr_count=1 after 4 cycles.
- Load (0000011), mem_ready delayed 3 cycles in both FETCH and MEM -> mem_read held throughout; iord=0 then 1. WB shows mem_to_reg=1, reg_write=1. instr_count=1.
- Branch (1100011): zero=1 gives pc_write=1, pc_src=1 in EXEC. Repeat with zero=0 -> pc_write=0. Both retire; count=2.
- Opcode 1111111 -> DECODE goes to TRAP (7) with illegal=1. Strobes stay 0 over 20 cycles. reset low -> state=0, illegal=0 asynchronously.
- Store with mem_ready held 0 in MEM, TIMEOUT=16 -> TRAP after 16 MEM cycles, timeout=1. Variant: mem_ready=1 on the 16th cycle -> FETCH, no timeout.
- CNT_W=4, run 17 I-ALU (0010011) instructions -> instr_count wraps to 1. Reset asserted in EXEC of the 18th -> count=0, no retire.
